// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM geometry and byte-lane encodings, reused by gfx and the VDP port logic.
package vram_arbiter_pkg;

    localparam int unsigned VRAM_AW = 13;
    localparam int unsigned VRAM_DW = 16;
    localparam int unsigned CPU_AW  = 14;

    localparam logic [1:0] BYTESEL_LO = 2'b01;
    localparam logic [1:0] BYTESEL_HI = 2'b10;

    // Byte lane from the CPU byte-address LSB.
    function automatic logic [1:0] lane_sel(input logic hi);
        return hi ? BYTESEL_HI : BYTESEL_LO;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: gfx has absolute priority, CPU byte accesses wait in a
// one-deep pending slot and issue only in cycles gfx leaves free.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 342,
    parameter int unsigned WAIT_W       = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gfx_req,
    input  logic [VRAM_AW-1:0]   gfx_vaddr,
    output logic [VRAM_DW-1:0]   gfx_vdata,
    input  logic [CPU_AW-1:0]    cpu_addr,
    input  logic [7:0]           cpu_wrdata,
    input  logic                 cpu_wr,
    input  logic                 cpu_rd,
    output logic                 cpu_busy,
    output logic [7:0]           cpu_rddata,
    output logic                 cpu_rddata_valid,
    output logic                 cpu_drop,
    output logic                 cpu_starved,
    output logic [VRAM_AW-1:0]   vram_addr,
    output logic [VRAM_DW-1:0]   vram_wrdata,
    output logic [1:0]           vram_bytesel,
    output logic                 vram_wren,
    input  logic [VRAM_DW-1:0]   vram_rddata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CPU_AW-1:0] slot_addr_q;
    logic [7:0]        slot_data_q;
    logic              slot_wr_q;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              accept;
    logic              grant;

    assign cpu_busy = (state_q != ST_IDLE);
    assign accept   = (state_q == ST_IDLE) && (cpu_wr || cpu_rd);
    // Grant only in a cycle gfx does not claim, so gfx is never stalled.
    assign grant    = (state_q == ST_PEND) && !gfx_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_PEND;
            ST_PEND:   if (grant) state_d = slot_wr_q ? ST_IDLE : ST_RDWAIT;
            ST_RDWAIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (accept) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_PEND) && gfx_req && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            slot_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                slot_addr_q <= cpu_addr;
                slot_data_q <= cpu_wrdata;
                slot_wr_q   <= cpu_wr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rddata       <= 8'h00;
            cpu_rddata_valid <= 1'b0;
            cpu_drop         <= 1'b0;
        end else begin
            cpu_rddata_valid <= (state_q == ST_RDWAIT);
            if (state_q == ST_RDWAIT) begin
                cpu_rddata <= slot_addr_q[0] ? vram_rddata[15:8] : vram_rddata[7:0];
            end
            // A simultaneous wr+rd keeps the write and drops the read.
            cpu_drop <= (cpu_busy && (cpu_wr || cpu_rd)) || (cpu_wr && cpu_rd);
        end
    end

    assign cpu_starved  = (state_q == ST_PEND) && (wait_cnt_q >= WAIT_W'(STARVE_LIMIT));
    assign vram_addr    = grant ? slot_addr_q[CPU_AW-1:1] : gfx_vaddr;
    assign vram_wren    = grant && slot_wr_q;
    assign vram_wrdata  = {slot_data_q, slot_data_q};
    assign vram_bytesel = vram_wren ? lane_sel(slot_addr_q[0]) : 2'b00;
    assign gfx_vdata    = vram_rddata;

endmodule
